// File: rtl/fetch_ctrl_pkg.sv
// Shared frontend fetch definitions: lane geometry, fetch FSM state encoding
// and a small popcount helper used for ibuffer occupancy accounting.
package fetch_ctrl_pkg;

    localparam int FETCH_LANES = 4;
    localparam int INST_W      = 32;
    localparam int FETCH_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } fetch_state_t;

    function automatic logic [2:0] popcount4(input logic [FETCH_LANES-1:0] m);
        popcount4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/fetch_lane_mask.sv
// Per-packet lane valid mask and next fetch PC. Optional predicted-taken
// truncation is enabled by defining FETCH_BPU_TRUNCATE_EN.
module fetch_lane_mask
    import fetch_ctrl_pkg::*;
(
    input  logic [63:2]                   pc_word,
    input  logic [FETCH_LANES-1:0]        predict_taken,
    input  logic [FETCH_LANES*INST_W-1:0] predict_target,
    output logic [FETCH_LANES-1:0]        lane_mask,
    output logic [63:0]                   next_pc
);

`ifdef FETCH_BPU_TRUNCATE_EN
    localparam bit TRUNC_EN = 1'b1;
`else
    localparam bit TRUNC_EN = 1'b0;
`endif

    logic [FETCH_LANES-1:0] start_mask;
    logic [63:0]            seq_pc;
    logic                   taken_seen;

    always_comb begin
        start_mask = '0;
        for (int i = 0; i < FETCH_LANES; i++) begin
            start_mask[i] = (i >= int'(pc_word[3:2]));
        end
        seq_pc = {pc_word[63:4], 4'b0000} + 64'(FETCH_BYTES);
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lane_mask  = start_mask;
        next_pc    = seq_pc;
        taken_seen = 1'b0;
        if (TRUNC_EN) begin
            // Only lanes at or after the start lane may redirect the stream.
            for (int i = 0; i < FETCH_LANES; i++) begin
                if (taken_seen) begin
                    lane_mask[i] = 1'b0;
                end else if (start_mask[i] && predict_taken[i]) begin
                    taken_seen = 1'b1;
                    next_pc    = 64'(predict_target[i*INST_W +: INST_W]);
                end
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Frontend fetch sequencer: one outstanding icache fetch, credit-paced by
// ibuffer occupancy, with redirect flush. Optional macro: FETCH_BPU_TRUNCATE_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          IB_DEPTH = 16,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          redirect_valid,
    input  logic [63:0]                   redirect_target,
    output logic                          fetch_req_valid,
    input  logic                          fetch_req_ready,
    output logic [63:0]                   fetch_req_pc,
    input  logic                          fetch_resp_valid,
    input  logic [FETCH_LANES*INST_W-1:0] fetch_resp_instr,
    input  logic [FETCH_LANES-1:0]        fetch_resp_predicttaken,
    input  logic [FETCH_LANES*INST_W-1:0] fetch_resp_predicttarget,
    output logic [FETCH_LANES*INST_W-1:0] ib_instr,
    output logic [FETCH_LANES-1:0]        ib_instr_valid,
    output logic [63:0]                   ib_pc,
    output logic [FETCH_LANES-1:0]        ib_predicttaken,
    output logic [FETCH_LANES*INST_W-1:0] ib_predicttarget,
    input  logic                          ibuffer_read_en,
    input  logic                          ibuffer_empty,
    input  logic                          mem_stall,
    output logic [$clog2(IB_DEPTH):0]     ib_occupancy
);

    localparam int OCC_W = $clog2(IB_DEPTH) + 1;

    fetch_state_t state_q, state_d;

    logic [63:0]                   pc_q, pc_d;
    logic [OCC_W-1:0]              occ_q, occ_d;
    logic [FETCH_LANES*INST_W-1:0] ib_instr_q, ib_instr_d;
    logic [FETCH_LANES-1:0]        ib_valid_q, ib_valid_d;
    logic [63:0]                   ib_pc_q, ib_pc_d;
    logic [FETCH_LANES-1:0]        ib_pt_q, ib_pt_d;
    logic [FETCH_LANES*INST_W-1:0] ib_ptgt_q, ib_ptgt_d;

    logic                   req_fire;
    logic                   pkt_load;
    logic                   pop_cnt;
    logic                   credit_ok;
    logic                   occ_underflow;
    logic [OCC_W-1:0]       occ_add;
    logic [FETCH_LANES-1:0] lane_mask;
    logic [63:0]            next_pc;

    fetch_lane_mask u_lane_mask (
        .pc_word        (pc_q[63:2]),
        .predict_taken  (fetch_resp_predicttaken),
        .predict_target (fetch_resp_predicttarget),
        .lane_mask      (lane_mask),
        .next_pc        (next_pc)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign credit_ok = (int'(occ_q) + FETCH_LANES) <= IB_DEPTH;

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            // A fired request or a DROP still waiting keeps one response in flight.
            unique case (state_q)
                ST_REQ:  state_d = req_fire ? ST_DROP : ST_IDLE;
                ST_WAIT: state_d = fetch_resp_valid ? ST_IDLE : ST_DROP;
                ST_DROP: state_d = fetch_resp_valid ? ST_IDLE : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: if (credit_ok)        state_d = ST_REQ;
                ST_REQ:  if (req_fire)         state_d = ST_WAIT;
                ST_WAIT: if (fetch_resp_valid) state_d = ST_IDLE;
                ST_DROP: if (fetch_resp_valid) state_d = ST_IDLE;
                default:                       state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fetch_req_valid = (state_q == ST_REQ);
        fetch_req_pc    = fetch_req_valid ? pc_q : '0;
        req_fire        = fetch_req_valid && fetch_req_ready;
        pkt_load        = (state_q == ST_WAIT) && fetch_resp_valid && !redirect_valid;
    end

    // Occupancy counts instructions at the edge the packet is registered, so the
    // IDLE credit check never sees a stale count.
    always_comb begin
        pop_cnt       = ibuffer_read_en && !ibuffer_empty && !mem_stall;
        occ_add       = occ_q + (pkt_load ? OCC_W'(popcount4(lane_mask)) : '0);
        occ_underflow = pop_cnt && (occ_add == '0) && !redirect_valid;

        pc_d       = pc_q;
        occ_d      = occ_add;
        ib_valid_d = '0;
        ib_instr_d = ib_instr_q;
        ib_pc_d    = ib_pc_q;
        ib_pt_d    = ib_pt_q;
        ib_ptgt_d  = ib_ptgt_q;

        if (pop_cnt && !occ_underflow) begin
            occ_d = occ_add - 1'b1;
        end

        if (redirect_valid) begin
            pc_d  = redirect_target;
            occ_d = '0;
        end else if (pkt_load) begin
            pc_d       = next_pc;
            ib_valid_d = lane_mask;
            ib_instr_d = fetch_resp_instr;
            ib_pc_d    = pc_q;
            ib_pt_d    = fetch_resp_predicttaken;
            ib_ptgt_d  = fetch_resp_predicttarget;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            occ_q      <= '0;
            ib_instr_q <= '0;
            ib_valid_q <= '0;
            ib_pc_q    <= '0;
            ib_pt_q    <= '0;
            ib_ptgt_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            occ_q      <= occ_d;
            ib_instr_q <= ib_instr_d;
            ib_valid_q <= ib_valid_d;
            ib_pc_q    <= ib_pc_d;
            ib_pt_q    <= ib_pt_d;
            ib_ptgt_q  <= ib_ptgt_d;
        end
    end

    assign ib_instr         = ib_instr_q;
    assign ib_instr_valid   = ib_valid_q;
    assign ib_pc            = ib_pc_q;
    assign ib_predicttaken  = ib_pt_q;
    assign ib_predicttarget = ib_ptgt_q;
    assign ib_occupancy     = occ_q;

    a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
        !occ_underflow);

    a_resp_expected: assert property (@(posedge clock) disable iff (!reset_n)
        fetch_resp_valid |-> (state_q == ST_WAIT || state_q == ST_DROP));

endmodule
